// File: rtl/pipe_pkg.sv
// Shared widths, bundle field offsets and occupancy encoding for the pipeline stage registers.
// Used by pipe_stage_skid; its statistics ports exist only when PIPE_STATS_EN is defined.
package pipe_pkg;

    // Per-boundary bundle widths
    localparam int ID_EX_CTRL_W  = 9;
    localparam int ID_EX_DATA_W  = 138;
    localparam int EX_MEM_CTRL_W = 6;
    localparam int EX_MEM_DATA_W = 101;
    localparam int MEM_WB_CTRL_W = 2;
    localparam int MEM_WB_DATA_W = 69;

    // EX/MEM control bit positions
    localparam int EXM_C_ZERO     = 0;
    localparam int EXM_C_REGWRITE = 1;
    localparam int EXM_C_BRANCH   = 2;
    localparam int EXM_C_MEMWRITE = 3;
    localparam int EXM_C_MEMREAD  = 4;
    localparam int EXM_C_MEMTOREG = 5;

    // EX/MEM data field LSB offsets (read_data2, alu_result_pc, alu_result are 32 bits, write_reg is 5)
    localparam int EXM_D_READ_DATA2    = 0;
    localparam int EXM_D_ALU_RESULT_PC = 32;
    localparam int EXM_D_ALU_RESULT    = 64;
    localparam int EXM_D_WRITE_REG     = 96;

    // MEM/WB data field LSB offsets
    localparam int MWB_D_WRITE_REG  = 0;
    localparam int MWB_D_ALU_RESULT = 5;
    localparam int MWB_D_READ_DATA  = 37;

    typedef enum logic [1:0] {
        OCC0 = 2'd0,
        OCC1 = 2'd1,
        OCC2 = 2'd2
    } occ_e;

    function automatic occ_e occ_of(input logic m_valid, input logic s_valid);
        if (s_valid)
            return OCC2;
        else if (m_valid)
            return OCC1;
        else
            return OCC0;
    endfunction

    function automatic logic [1:0] popcount2(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: adds inc_amt each cycle, sticks at all-ones, cleared by rst.
// Instantiated by pipe_stage_skid only when PIPE_STATS_EN is defined.
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   inc_amt,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W+1:0] sum;

    always_comb begin
        sum     = {2'b00, count_q} + {{W{1'b0}}, inc_amt};
        count_d = (sum > {2'b00, {W{1'b1}}}) ? {W{1'b1}} : sum[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush.
// Define PIPE_STATS_EN to add the saturating stat_stall / stat_flush counters.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EX_MEM_CTRL_W,
    parameter int DATA_W = EX_MEM_DATA_W
`ifdef PIPE_STATS_EN
    ,
    parameter int STAT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_stall,
    output logic [STAT_W-1:0] stat_flush
`endif
);

    logic              m_valid_q, m_valid_d;
    logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;
    logic              s_valid_q, s_valid_d;
    logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;

    occ_e occ;
    logic acc_in;
    logic acc_out;

    always_comb begin
        occ     = occ_of(m_valid_q, s_valid_q);
        // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally
        acc_in  = in_valid && !s_valid_q;
        acc_out = m_valid_q && out_ready;

        m_valid_d = m_valid_q;
        m_ctrl_d  = m_ctrl_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_ctrl_d  = s_ctrl_q;
        s_data_d  = s_data_q;

        if (flush) begin
            // Data registers keep their contents; only valids and control are squashed
            m_valid_d = 1'b0;
            m_ctrl_d  = '0;
            s_valid_d = 1'b0;
            s_ctrl_d  = '0;
        end else begin
            case (occ)
                OCC0: begin
                    if (acc_in) begin
                        m_valid_d = 1'b1;
                        m_ctrl_d  = in_ctrl;
                        m_data_d  = in_data;
                    end
                end
                OCC1: begin
                    if (acc_in && acc_out) begin
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                    end else if (acc_in) begin
                        s_valid_d = 1'b1;
                        s_ctrl_d  = in_ctrl;
                        s_data_d  = in_data;
                    end else if (acc_out) begin
                        m_valid_d = 1'b0;
                        m_ctrl_d  = '0;
                    end
                end
                OCC2: begin
                    if (acc_out) begin
                        m_ctrl_d  = s_ctrl_q;
                        m_data_d  = s_data_q;
                        s_valid_d = 1'b0;
                        s_ctrl_d  = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_ctrl_q  <= '0;
            m_data_q  <= '0;
            s_valid_q <= 1'b0;
            s_ctrl_q  <= '0;
            s_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_ctrl_q  <= m_ctrl_d;
            m_data_q  <= m_data_d;
            s_valid_q <= s_valid_d;
            s_ctrl_q  <= s_ctrl_d;
            s_data_q  <= s_data_d;
        end
    end

    assign in_ready  = !s_valid_q;
    assign out_valid = m_valid_q;
    assign out_ctrl  = m_ctrl_q & {CTRL_W{m_valid_q}};
    assign out_data  = m_data_q;

`ifdef PIPE_STATS_EN
    pipe_sat_counter #(.W(STAT_W)) u_stat_stall (
        .clk     (clk),
        .rst     (rst),
        .inc_amt ({1'b0, m_valid_q && !out_ready}),
        .count   (stat_stall)
    );

    pipe_sat_counter #(.W(STAT_W)) u_stat_flush (
        .clk     (clk),
        .rst     (rst),
        .inc_amt (flush ? popcount2(m_valid_q, s_valid_q) : 2'b00),
        .count   (stat_flush)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: table vectors, corner sequences and a random run against a queue model.
// Stat counters are checked too when PIPE_STATS_EN is defined.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int CW = EX_MEM_CTRL_W;
    localparam int DW = EX_MEM_DATA_W;
`ifdef PIPE_STATS_EN
    localparam int SW = 4;
    localparam int SMAX = (1 << SW) - 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
`ifdef PIPE_STATS_EN
    logic [SW-1:0] stat_stall;
    logic [SW-1:0] stat_flush;
`endif

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .CTRL_W (CW),
        .DATA_W (DW)
`ifdef PIPE_STATS_EN
        , .STAT_W (SW)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
`ifdef PIPE_STATS_EN
        , .stat_stall (stat_stall)
        , .stat_flush (stat_flush)
`endif
    );

    typedef struct {
        logic          rst;
        logic          iv;
        logic [CW-1:0] ictrl;
        logic [DW-1:0] idata;
        logic          ordy;
        logic          fl;
        logic          ov;
        logic          ir;
        logic [CW-1:0] octrl;
        logic [DW-1:0] odata;
    } vec_t;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    vec_t  vecs[24];
    beat_t sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    stall_exp = 0;
    int    flush_exp = 0;

    function automatic vec_t mk(int r, int iv, int c, int d, int ordy, int fl,
                                int ov, int ir, int oc, int od);
        vec_t v;
        v.rst   = r[0];
        v.iv    = iv[0];
        v.ictrl = CW'(c);
        v.idata = DW'(d);
        v.ordy  = ordy[0];
        v.fl    = fl[0];
        v.ov    = ov[0];
        v.ir    = ir[0];
        v.octrl = CW'(oc);
        v.odata = DW'(od);
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s step=%0d got=%0h exp=%0h", name, idx, got, exp);
        end
    endtask

    // Drive one cycle, advance the queue model at the edge, then compare 1 time unit later
    task automatic step(input vec_t v, input bit use_exp, input int idx);
        int sz;
        rst       = v.rst;
        in_valid  = v.iv;
        in_ctrl   = v.ictrl;
        in_data   = v.idata;
        out_ready = v.ordy;
        flush     = v.fl;
        @(posedge clk);
        sz = sb.size();
        if (v.rst) begin
            sb.delete();
            stall_exp = 0;
            flush_exp = 0;
        end else begin
`ifdef PIPE_STATS_EN
            if (sz > 0 && !v.ordy && stall_exp < SMAX)
                stall_exp++;
            if (v.fl)
                flush_exp = (flush_exp + sz > SMAX) ? SMAX : flush_exp + sz;
`endif
            if (v.fl) begin
                sb.delete();
            end else begin
                if (v.ordy && sz > 0)
                    void'(sb.pop_front());
                if (v.iv && sz < 2)
                    sb.push_back('{v.ictrl, v.idata});
            end
        end
        #1;
        check("model_out_valid", idx, DW'(out_valid), DW'(sb.size() != 0));
        check("model_in_ready",  idx, DW'(in_ready),  DW'(sb.size() < 2));
        if (sb.size() != 0) begin
            check("model_out_ctrl", idx, DW'(out_ctrl), DW'(sb[0].c));
            check("model_out_data", idx, out_data, sb[0].d);
        end else begin
            check("model_bubble_ctrl", idx, DW'(out_ctrl), '0);
        end
`ifdef PIPE_STATS_EN
        check("model_stat_stall", idx, DW'(stat_stall), DW'(stall_exp));
        check("model_stat_flush", idx, DW'(stat_flush), DW'(flush_exp));
`endif
        if (use_exp) begin
            check("vec_out_valid", idx, DW'(out_valid), DW'(v.ov));
            check("vec_in_ready",  idx, DW'(in_ready),  DW'(v.ir));
            check("vec_out_ctrl",  idx, DW'(out_ctrl),  DW'(v.octrl));
            check("vec_out_data",  idx, out_data,       v.odata);
        end
    endtask

    initial begin
        //            rst iv ctrl  data  ordy fl | ov ir octrl odata
        vecs[0]  = mk(1, 1, 'h3F, 'h99, 1, 0,   0, 1, 'h00, 'h00); // reset hold
        vecs[1]  = mk(1, 1, 'h3F, 'h99, 1, 0,   0, 1, 'h00, 'h00);
        vecs[2]  = mk(0, 1, 'h01, 'h01, 1, 0,   1, 1, 'h01, 'h01); // streaming 1..4
        vecs[3]  = mk(0, 1, 'h02, 'h02, 1, 0,   1, 1, 'h02, 'h02);
        vecs[4]  = mk(0, 1, 'h03, 'h03, 1, 0,   1, 1, 'h03, 'h03);
        vecs[5]  = mk(0, 1, 'h04, 'h04, 1, 0,   1, 1, 'h04, 'h04);
        vecs[6]  = mk(0, 0, 'h3F, 'h00, 1, 0,   0, 1, 'h00, 'h04); // drain, data reg held
        vecs[7]  = mk(0, 0, 'h3F, 'h55, 1, 0,   0, 1, 'h00, 'h04); // bubble masking
        vecs[8]  = mk(0, 1, 'h0A, 'h0A, 1, 0,   1, 1, 'h0A, 'h0A); // A
        vecs[9]  = mk(0, 1, 'h0B, 'h0B, 0, 0,   1, 0, 'h0A, 'h0A); // B into skid
        vecs[10] = mk(0, 1, 'h0C, 'h0C, 0, 0,   1, 0, 'h0A, 'h0A); // C refused
        vecs[11] = mk(0, 0, 'h00, 'h00, 1, 0,   1, 1, 'h0B, 'h0B); // A out, B to main
        vecs[12] = mk(0, 0, 'h00, 'h00, 1, 0,   0, 1, 'h00, 'h0B); // B out
        vecs[13] = mk(0, 1, 'h0D, 'h0D, 0, 0,   1, 1, 'h0D, 'h0D);
        vecs[14] = mk(0, 1, 'h0E, 'h0E, 0, 0,   1, 0, 'h0D, 'h0D); // occ2
        vecs[15] = mk(0, 1, 'h0C, 'h0C, 0, 1,   0, 1, 'h00, 'h0D); // flush at occ2
        vecs[16] = mk(0, 1, 'h0F, 'h0F, 0, 0,   1, 1, 'h0F, 'h0F);
        vecs[17] = mk(0, 1, 'h10, 'h10, 1, 1,   0, 1, 'h00, 'h0F); // flush beats acc_in
        vecs[18] = mk(0, 0, 'h00, 'h00, 1, 0,   0, 1, 'h00, 'h0F);
        vecs[19] = mk(0, 1, 'h11, 'h11, 0, 0,   1, 1, 'h11, 'h11);
        vecs[20] = mk(0, 1, 'h12, 'h12, 0, 0,   1, 0, 'h11, 'h11);
        vecs[21] = mk(1, 1, 'h3F, 'h3F, 0, 0,   0, 1, 'h00, 'h00); // mid-stream reset
        vecs[22] = mk(0, 1, 'h13, 'h13, 1, 0,   1, 1, 'h13, 'h13);
        vecs[23] = mk(0, 0, 'h00, 'h00, 1, 0,   0, 1, 'h00, 'h13);

        for (int i = 0; i < 24; i++)
            step(vecs[i], 1'b1, i);

        // Flush at occupancy 2 with a simultaneous beat
        step(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b1, 100);
        step(mk(0, 1, 'h21, 'h21, 0, 0, 1, 1, 'h21, 'h21), 1'b1, 101);
        step(mk(0, 1, 'h22, 'h22, 0, 0, 1, 0, 'h21, 'h21), 1'b1, 102);
        step(mk(0, 1, 'h23, 'h23, 0, 1, 0, 1, 'h00, 'h21), 1'b1, 103);
`ifdef PIPE_STATS_EN
        check("stat_flush_two", 103, DW'(stat_flush), DW'(2));
`endif
        step(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 'h21), 1'b1, 104);

        // Long stall: data held, stall counter saturates
        step(mk(0, 1, 'h2A, 'h2A, 0, 0, 1, 1, 'h2A, 'h2A), 1'b1, 200);
        for (int i = 0; i < 20; i++)
            step(mk(0, 0, 'h3F, 'h77, 0, 0, 1, 1, 'h2A, 'h2A), 1'b1, 201 + i);
`ifdef PIPE_STATS_EN
        check("stat_stall_sat", 220, DW'(stat_stall), DW'(SMAX));
`endif
        step(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b1, 221);
`ifdef PIPE_STATS_EN
        check("stat_stall_after_rst", 221, DW'(stat_stall), '0);
`endif

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            vec_t v;
            v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            v.rst   = ($urandom_range(0, 99) == 0);
            v.iv    = ($urandom_range(0, 3) != 0);
            v.ictrl = CW'($urandom);
            v.idata = DW'({$urandom, $urandom, $urandom, $urandom});
            v.ordy  = ($urandom_range(0, 2) != 0);
            v.fl    = ($urandom_range(0, 15) == 0);
            step(v, 1'b0, 1000 + i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- One generic stage register carries a control bundle and a data bundle, with a valid/ready handshake, a 2-entry skid buffer for full-throughput stalls, and a flush for branch squash.
- Instantiated between every pair of pipeline stages, with widths set per boundary.

Parameters:
- CTRL_W, 6, width of control bundle (MemtoReg, MemRead, MemWrite, Branch, RegWrite, zero, ...); forced to 0 on bubbles
- DATA_W, 101, width of data bundle (write_reg, alu_result, alu_result_pc, read_data2, ...); never masked
- STAT_W, 16, width of statistics counters (used only with PIPE_STATS_EN)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  upstream stage holds a valid instruction
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- flush  in  1  squash all held and incoming entries
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  main control, ANDed with out_valid (bubble = all zero)
- out_data  out  DATA_W  main data, raw register
- stat_stall  out  STAT_W  (PIPE_STATS_EN only) cycles with out_valid && !out_ready
- stat_flush  out  STAT_W  (PIPE_STATS_EN only) valid entries discarded by flush

Behaviour:
- State: main entry {m_valid, m_ctrl, m_data} and skid entry {s_valid, s_ctrl, s_data}. Occupancy is 0, 1 or 2.
- Handshake events: acc_in = in_valid && in_ready; acc_out = out_valid && out_ready.
- Reset (rst=1 at edge): m_valid=s_valid=0, m_ctrl=s_ctrl=0, m_data=s_data=0. Outputs: out_valid=0, in_ready=1, out_ctrl=0, out_data=0, stats=0. Reset overrides flush and all handshakes; a mid-stream reset drops everything.
- Flush (flush=1, rst=0): next state is m_valid=s_valid=0 and m_ctrl=0. An input offered in the same cycle is discarded, even if acc_in. Data registers hold their values. in_ready becomes 1 in the next cycle.
- Normal transitions (flush=0):
  - occ0, acc_in: load main. Result occ1.
  - occ1, acc_in && acc_out: main gets input. Result occ1.
  - occ1, acc_in && !acc_out: input goes to skid. Result occ2, in_ready=0 next cycle.
  - occ1, !acc_in && acc_out: main cleared. Result occ0.
  - occ2, acc_out: main gets skid, skid cleared. Result occ1, in_ready=1 next cycle.
  - occ2: acc_in is impossible because in_ready=0.
- Latency and throughput:
  - Latency is 1 cycle in-to-out when empty.
  - Throughput is 1/cycle with out_ready held at 1.
  - No combinational path from out_ready to in_ready.
- Ordering: strictly FIFO. The skid entry is never output before the main entry.
- out_valid=0 forces out_ctrl=0, so downstream never writes register file or memory on a bubble.
- in_valid=0 inputs are never captured; data X on those cycles must not propagate.

Optional Feature:
- PIPE_STATS_EN defined:
  - stat_stall increments on each cycle with out_valid && !out_ready.
  - stat_flush adds popcount(m_valid, s_valid) on each flush cycle.
  - Both counters saturate at all-ones and clear on rst.
- PIPE_STATS_EN undefined: stat ports and counters are absent, and no logic is generated.

Decomposition:
- Shared package pipe_pkg holds:
  - per-boundary widths: EX_MEM_CTRL_W=6, EX_MEM_DATA_W=101, ID_EX_*, MEM_WB_*
  - field offset constants for packing and unpacking bundles
  - a typedef for the occupancy encoding (OCC0, OCC1, OCC2)
- Natural sub-module: pipe_sat_counter (STAT_W saturating counter with increment amount and clear), instantiated twice under PIPE_STATS_EN.

Test Plan:
- Reset hold: rst=1 for 2 cycles with in_valid=1, in_ctrl=6'h3F -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1. After release, the first accepted beat appears 1 cycle later.
- Streaming: out_ready=1, in_valid=1, data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 on the next four cycles, in_ready stays 1.
- Stall and skid: send A and B, drop out_ready=0 while B is accepted -> in_ready=0 next cycle, out_data holds A. Raise out_ready -> A, then B, then in_ready=1.
- Flush at occupancy 2 with a simultaneous in_valid=1 beat C -> next cycle out_valid=0, out_ctrl=0, in_ready=1, C never appears. With stats enabled, stat_flush=2.
- Bubble masking: in_valid=0, in_ctrl=6'h3F, out_ready=1 -> out_ctrl=0 every cycle.
- Stats saturation (PIPE_STATS_EN, STAT_W=4): hold a stall for 20 cycles -> stat_stall=15 and stays there. After rst it reads 0.
